// File: rtl/bytes_to_colors_if.sv
// rtl/bytes_to_colors_if.sv - byte-in / color-out strobe bundle for bytes_to_colors
//
// Signals:
//   inclk   : input byte strobe (source -> repacker)
//   in      : input byte
//   in_done : end-of-stream strobe (source -> repacker)
//   outclk  : one-cycle color strobe (repacker -> sink)
//   out     : color, R=[11:8] G=[7:4] B=[3:0]
//   done    : one-cycle end-of-stream acknowledge (repacker -> sink)
// Modports: master = byte source / color sink side, slave = repacker side.
interface bytes_to_colors_if #(
  parameter int BYTE_LEN  = 8,
  parameter int COLOR_LEN = 12
);
  logic                 inclk;
  logic [BYTE_LEN-1:0]  in;
  logic                 in_done;
  logic                 outclk;
  logic [COLOR_LEN-1:0] out;
  logic                 done;

  modport master (
    output inclk, in, in_done,
    input  outclk, out, done
  );

  modport slave (
    input  inclk, in, in_done,
    output outclk, out, done
  );
endinterface

// File: rtl/bytes_to_colors.sv
// rtl/bytes_to_colors.sv - repacks a byte stream into 12-bit RGB444 colors (3 bytes -> 2 colors)
//
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : bytes_to_colors_if.slave (inclk/in/in_done in, outclk/out/done out)
// Outputs are registered: a color appears the cycle after the accepting edge.
module bytes_to_colors #(
  parameter int BYTE_LEN  = 8,
  parameter int COLOR_LEN = 12
) (
  input  logic                clk,
  input  logic                rst,
  bytes_to_colors_if.slave    bus
);

  localparam int HALF = BYTE_LEN / 2;

  logic [1:0]           r_phase;
  logic [BYTE_LEN-1:0]  r_hold;
  logic                 r_flush_pend;
  logic                 r_outclk;
  logic [COLOR_LEN-1:0] r_out;
  logic                 r_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase      <= 2'd0;
      r_hold       <= '0;
      r_flush_pend <= 1'b0;
      r_outclk     <= 1'b0;
      r_out        <= '0;
      r_done       <= 1'b0;
    end else begin
      r_outclk <= 1'b0;
      r_done   <= 1'b0;
      if (bus.inclk) begin
        case (r_phase)
          2'd1: begin
            r_out    <= {r_hold, bus.in[BYTE_LEN-1 -: HALF]};
            r_outclk <= 1'b1;
            r_hold   <= {{HALF{1'b0}}, bus.in[HALF-1:0]};
            r_phase  <= 2'd2;
          end
          2'd2: begin
            r_out    <= {r_hold[HALF-1:0], bus.in};
            r_outclk <= 1'b1;
            r_phase  <= 2'd0;
          end
          // Phase 3 is unreachable; treat it as phase 0 so the group restarts cleanly.
          default: begin
            r_hold  <= bus.in;
            r_phase <= 2'd1;
          end
        endcase
        // A flush arriving with a byte is deferred so the byte's own color goes first.
        if (bus.in_done) begin
          r_flush_pend <= 1'b1;
        end
      end else if (bus.in_done || r_flush_pend) begin
        case (r_phase)
          2'd1: begin
            r_out    <= {r_hold, {HALF{1'b0}}};
            r_outclk <= 1'b1;
          end
          2'd2: begin
            r_out    <= {r_hold[HALF-1:0], {BYTE_LEN{1'b0}}};
            r_outclk <= 1'b1;
          end
          default: ;
        endcase
        r_phase      <= 2'd0;
        r_done       <= 1'b1;
        r_flush_pend <= 1'b0;
      end
    end
  end

  assign bus.outclk = r_outclk;
  assign bus.out    = r_out;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_bytes_to_colors.sv
// tb/tb_bytes_to_colors.sv - scoreboard bench for bytes_to_colors
module tb_bytes_to_colors;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   cyc;

  bytes_to_colors_if #(.BYTE_LEN(8), .COLOR_LEN(12)) bus ();

  bytes_to_colors #(.BYTE_LEN(8), .COLOR_LEN(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] color;
    bit          has_color;
    bit          done;
    int          at_cyc;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: bytes of the current group kept whole.
  int         m_count;
  logic [7:0] m_b0;
  logic [7:0] m_b1;
  bit         m_pend;
  logic [11:0] last_color;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [11:0] c, input bit hc, input bit d, input int e);
    exp_t x;
    x.color = c; x.has_color = hc; x.done = d; x.at_cyc = e;
    exp_q.push_back(x);
  endtask

  // Drive one cycle of inputs; they are consumed by the next rising edge.
  task automatic drive(input bit v, input logic [7:0] b, input bit d);
    int e;
    e = cyc + 1;
    bus.inclk = v; bus.in = b; bus.in_done = d;
    if (rst) begin
      if (v) begin
        if (m_count == 0) begin
          m_b0 = b; m_count = 1;
        end else if (m_count == 1) begin
          m_b1 = b; m_count = 2;
          push({m_b0, m_b1[7:4]}, 1, 0, e);
        end else begin
          m_count = 0;
          push({m_b1[3:0], b}, 1, 0, e);
        end
        if (d) m_pend = 1;
      end else if (d || m_pend) begin
        if (m_count == 1)      push({m_b0, 4'h0}, 1, 1, e);
        else if (m_count == 2) push({m_b1[3:0], 8'h00}, 1, 1, e);
        else                   push(12'h000, 0, 1, e);
        m_count = 0; m_pend = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 8'h00, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_outclk", {31'd0, bus.outclk}, 32'd0);
      check("rst_done",   {31'd0, bus.done},   32'd0);
      check("rst_out",    {20'd0, bus.out},    32'd0);
    end else if (bus.outclk || bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {19'd0, bus.done, bus.outclk, bus.out}, 32'd0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("outclk", {31'd0, bus.outclk}, {31'd0, x.has_color});
        check("done",   {31'd0, bus.done},   {31'd0, x.done});
        check("cycle",  cyc, x.at_cyc);
        if (x.has_color) begin
          check("color", {20'd0, bus.out}, {20'd0, x.color});
          last_color = x.color;
        end
      end
    end else begin
      check("out_hold", {20'd0, bus.out}, {20'd0, last_color});
    end
  end

  initial begin
    logic [7:0] burst [6];
    n_checks = 0; n_errors = 0; cyc = 0;
    m_count = 0; m_pend = 0; m_b0 = 0; m_b1 = 0; last_color = 0;
    rst = 1'b0;
    bus.inclk = 0; bus.in = 0; bus.in_done = 0;

    // Reset held with strobes toggling: nothing may come out.
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) drive(i[0], 8'hA0 + 8'(i), 1'b0);
    rst = 1'b1;
    idle(2);

    // Back-to-back: DE AD BE EF CA FE -> DEA DBE EFC AFE
    burst[0] = 8'hDE; burst[1] = 8'hAD; burst[2] = 8'hBE;
    burst[3] = 8'hEF; burst[4] = 8'hCA; burst[5] = 8'hFE;
    for (int i = 0; i < 6; i++) drive(1, burst[i], 0);
    idle(3);

    // Sparse: 12, 34, 56 with 3 idle cycles between
    drive(1, 8'h12, 0); idle(3);
    drive(1, 8'h34, 0); idle(3);
    drive(1, 8'h56, 0); idle(3);

    // Flush after one byte: A50 + done
    drive(1, 8'hA5, 0); idle(1);
    drive(0, 8'h00, 1); idle(2);

    // Flush after two bytes: 123, then 400 + done
    drive(1, 8'h12, 0); drive(1, 8'h34, 0); idle(2);
    drive(0, 8'h00, 1); idle(2);

    // in_done on the same edge as the second byte
    drive(1, 8'h12, 0); drive(1, 8'h34, 1); idle(3);

    // Flush with nothing pending: done only
    drive(0, 8'h00, 1); idle(2);

    // Three bytes then a flush that lands on the phase-0 group boundary
    drive(1, 8'h9A, 0); drive(1, 8'hBC, 0); drive(1, 8'hDE, 1); idle(3);

    // Reset mid-group drops the held byte
    drive(1, 8'h77, 0);
    rst = 1'b0; m_count = 0; m_pend = 0; last_color = 12'h000;
    idle(2);
    rst = 1'b1;
    idle(1);
    drive(1, 8'h01, 0); drive(1, 8'h23, 0); drive(1, 8'h45, 0);
    idle(4);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bytes_to_colors.md
Name: bytes_to_colors

Overview:
- Repacks a byte stream into 12-bit RGB444 pixel colors: every 3 input bytes (24 bits) yield 2 colors.
- Sits between byte sources (UART/Ethernet payload stream) and stream_to_memory, which writes colors into the video cache RAM.
- Strobe-based, no backpressure. Optional end-of-stream flush emits any partial color, zero-padded.

Parameters:
- BYTE_LEN, 8, input word width in bits.
- COLOR_LEN, 12, output color width in bits; fixed at 12 (3×BYTE_LEN = 2×COLOR_LEN).

Ports:
- clk  input  1  system clock (50 MHz domain); all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- inclk  input  1  input strobe; in is valid and consumed on any rising edge where inclk=1.
- in  input  BYTE_LEN  input byte.
- in_done  input  1  end-of-stream strobe; flushes a pending partial color.
- outclk  output  1  one-cycle strobe; out is valid while outclk=1.
- out  output  COLOR_LEN  output color, R=[11:8], G=[7:4], B=[3:0].
- done  output  1  one-cycle strobe one cycle after in_done has been processed.

Behaviour:
- Reset (rst=0, asynchronous):
  - phase=0; holding register=0.
  - outclk=0, out=0, done=0.
- Phase counter 0→1→2→0 advances on each accepted byte (inclk=1). Holding register is 8 bits.
- phase 0, byte B0:
  - Store B0; no output.
- phase 1, byte B1:
  - Next cycle: out={B0, B1[7:4]}, outclk=1.
  - Store B1[3:0].
- phase 2, byte B2:
  - Next cycle: out={B1[3:0], B2}, outclk=1.
  - Phase returns to 0.
- Latency: outclk/out registered, asserted the clock after the accepting edge.
- Back-to-back bytes every cycle are supported: sustained throughput of 2 colors per 3 cycles.
- outclk is high for exactly one cycle per color. out holds its last value when outclk=0.
- in_done handling (only on an edge where inclk=0):
  - phase 1: emit {held B0, 4'h0}.
  - phase 2: emit {held B1[3:0], 8'h00}.
  - phase 0: no color emitted.
  - In all cases phase returns to 0 and done pulses one cycle after the in_done edge, together with any flush color.
- in_done and inclk high on the same edge:
  - The byte is accepted first (normal output rules).
  - The flush then applies to the resulting phase on the next cycle: flush color, if any, plus done, one cycle after the normal output.
  - At most one output per cycle; the flush output is delayed by one cycle if it collides.
- inclk while rst=0: ignored.
- Reset mid-group discards the partial bytes; no output.
- No overflow condition exists. The phase counter uses only 2 bits; value 3 is unreachable and must recover to 0.

Test Plan:
- Reset:
  - Stimulus: hold rst=0, toggle inclk.
  - Required: outclk=0, done=0, out=0 throughout.
- Six back-to-back bytes DE AD BE EF CA FE (inclk high 6 cycles):
  - Required colors: DEA, DBE, EFC, AFE.
  - outclk pulses 1 cycle after the 2nd, 3rd, 5th and 6th accepted bytes.
  - Results written into the video cache RAM via stream_to_memory at addresses 0..3.
- Sparse input, bytes 12 34 56 with 3 idle cycles between each:
  - Required: 123 one cycle after 34 is accepted, 456 one cycle after 56.
  - No extra outclk pulses.
- Flush after one byte A5, then in_done:
  - Required: out=A50 with outclk, and done in the same cycle.
- Flush after bytes 12 34, then in_done:
  - Required: 123 on the first output, then 400 plus done on the next in_done.
  - Repeat with in_done in the same edge as byte 34: required 123, then 400 plus done one cycle later.
- Assert rst=0 after one byte 77, release, then send 01 23 45:
  - Required: 012, 345 only; 77 is never emitted.
